// File: rtl/blink_scheduler.sv
// LED blink sequencer: one shared prescaler drives NCH period/on-time channels.
// Channel reconfiguration while running is staged and applied only on a tick.
module blink_scheduler #(
    parameter int NCH   = 4,
    parameter int CBITS = 20,
    parameter int PBITS = 8,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [PBITS-1:0] cfg_period,
    input  logic [PBITS-1:0] cfg_on,
    output logic [NCH-1:0]   led,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t             state_reg, state_next;
    logic [CBITS-1:0]   cnt_reg;
    logic               tick_reg;
    logic               busy_reg, busy_next;
    logic [NCH-1:0]     led_reg, led_next;
    logic               pend_valid_reg;
    logic [CHW-1:0]     pend_ch_reg;
    logic [PBITS-1:0]   pend_period_reg, pend_on_reg;
    logic               accept, start_go, wrap, ch_ok;

    assign cfg_ready = !pend_valid_reg;
    assign accept    = cfg_valid && !pend_valid_reg;
    assign start_go  = (state_reg == IDLE) && start;
    assign wrap      = busy_reg && (cnt_reg == {CBITS{1'b1}});
    assign ch_ok     = {1'b0, cfg_ch} < (CHW+1)'(NCH);
    assign led       = led_reg;
    assign tick      = tick_reg;
    assign busy      = busy_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = RUN;
            RUN:      if (stop)  state_next = STOPPING;
            STOPPING: if (wrap)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            tick_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            led_reg         <= '0;
            pend_valid_reg  <= 1'b0;
            pend_ch_reg     <= '0;
            pend_period_reg <= '0;
            pend_on_reg     <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            tick_reg  <= wrap;
            led_reg   <= led_next;
            if (start_go)
                cnt_reg <= '0;
            else if (busy_reg)
                cnt_reg <= cnt_reg + CBITS'(1);
            if (wrap && pend_valid_reg)
                pend_valid_reg <= 1'b0;
            // Slot is empty whenever accept is high, so this never races the release above.
            if (accept && state_reg != IDLE && ch_ok) begin
                pend_valid_reg  <= 1'b1;
                pend_ch_reg     <= cfg_ch;
                pend_period_reg <= cfg_period;
                pend_on_reg     <= cfg_on;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [CHW-1:0] CH_ID = CHW'(gi);

        logic [PBITS-1:0] period_reg, on_reg, phase_reg;
        logic [PBITS-1:0] period_next, on_next, phase_next;
        logic             wr_direct, wr_pend;

        assign wr_direct = accept && (state_reg == IDLE) && (cfg_ch == CH_ID);
        assign wr_pend   = wrap && pend_valid_reg && (pend_ch_reg == CH_ID);

        always_comb begin
            period_next = period_reg;
            on_next     = on_reg;
            phase_next  = phase_reg;
            if (wr_direct) begin
                period_next = cfg_period;
                on_next     = cfg_on;
            end else if (wr_pend) begin
                period_next = pend_period_reg;
                on_next     = pend_on_reg;
            end
            if (start_go || (wrap && (state_reg == STOPPING || wr_pend || period_reg == '0)))
                phase_next = '0;
            else if (wrap)
                phase_next = (phase_reg == period_reg - PBITS'(1)) ? '0 : phase_reg + PBITS'(1);
        end

        // LED is judged on next-state values so it switches on the same edge as tick.
        assign led_next[gi] = busy_next && (period_next != '0) && (phase_next < on_next);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                period_reg <= '0;
                on_reg     <= '0;
                phase_reg  <= '0;
            end else begin
                period_reg <= period_next;
                on_reg     <= on_next;
                phase_reg  <= phase_next;
            end
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler with a per-tick-interval scoreboard of expected LED states.
module tb_blink_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic       cfg_valid, cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period, cfg_on;
    logic [3:0] led;
    logic       tick, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] led;
        int         cfg_at;
        logic [1:0] ch;
        logic [7:0] per;
        logic [7:0] on;
        int         stop_at;
        int         start_at;
        bit         last;
    } item_t;

    item_t sb[$];
    item_t tmp;

    blink_scheduler #(.NCH(4), .CBITS(3), .PBITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .led        (led),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic item_t mk(input logic [3:0] l);
        item_t it;
        it.led = l; it.cfg_at = -1; it.ch = 2'd0; it.per = 8'd0; it.on = 8'd0;
        it.stop_at = -1; it.start_at = -1; it.last = 1'b0;
        return it;
    endfunction

    // Entered at the negedge opening an interval; leaves at the negedge after the closing tick.
    task automatic run_interval(input item_t it);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("led_c%0d", c), 32'(led), 32'(it.led));
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            if (c > 0) chk($sformatf("tick_low_c%0d", c), 32'(tick), 32'd0);
            chk($sformatf("cfg_ready_c%0d", c), 32'(cfg_ready),
                (it.cfg_at >= 0 && c > it.cfg_at) ? 32'd0 : 32'd1);
            cfg_valid  = (c == it.cfg_at);
            cfg_ch     = it.ch;
            cfg_period = it.per;
            cfg_on     = it.on;
            start      = (c == it.start_at);
            stop       = (c == it.stop_at);
            @(negedge clk);
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        chk("tick_high", 32'(tick), 32'd1);
        if (it.cfg_at >= 0) chk("ready_after_apply", 32'(cfg_ready), 32'd1);
        if (it.last) begin
            chk("led_off_at_stop", 32'(led), 32'd0);
            chk("busy_off_at_stop", 32'(busy), 32'd0);
        end
        $display("interval led=%b cfg_at=%0d stop_at=%0d start_at=%0d last=%0d",
                 it.led, it.cfg_at, it.stop_at, it.start_at, it.last);
    endtask

    task automatic drain();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_interval(it);
        end
    endtask

    task automatic cfg_idle(input logic [1:0] ch, input logic [7:0] per, input logic [7:0] on);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_period = per; cfg_on = on;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        $display("idle cfg ch=%0d period=%0d on=%0d", ch, per, on);
    endtask

    task automatic pulse(input logic st, input logic sp);
        start = st; stop = sp;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("tick_at_start", 32'(tick), 32'd0);
        $display("pulse start=%0d stop=%0d", st, sp);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_period = 8'd0; cfg_on = 8'd0;
        @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b1;

        cfg_idle(2'd0, 8'd4, 8'd2);
        cfg_idle(2'd1, 8'd3, 8'd5);
        cfg_idle(2'd2, 8'd0, 8'd3);
        chk("idle_led", 32'(led), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        pulse(1'b1, 1'b0);
        sb.push_back(mk(4'b0011));
        sb.push_back(mk(4'b0011));
        sb.push_back(mk(4'b0010));
        sb.push_back(mk(4'b0010));
        sb.push_back(mk(4'b0011));
        tmp = mk(4'b0011); tmp.cfg_at = 2; tmp.ch = 2'd0; tmp.per = 8'd2; tmp.on = 8'd1;
        sb.push_back(tmp);
        sb.push_back(mk(4'b0011));
        sb.push_back(mk(4'b0010));
        tmp = mk(4'b0011); tmp.stop_at = 2; tmp.last = 1'b1;
        sb.push_back(tmp);
        drain();

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_stop_led", 32'(led), 32'd0);
            chk("post_stop_busy", 32'(busy), 32'd0);
            chk("post_stop_tick", 32'(tick), 32'd0);
        end

        pulse(1'b1, 1'b1);
        sb.push_back(mk(4'b0011));
        tmp = mk(4'b0010); tmp.start_at = 3;
        sb.push_back(tmp);
        sb.push_back(mk(4'b0011));
        sb.push_back(mk(4'b0010));
        drain();

        chk("pre_rst_led", 32'(led), 32'd3);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd2; cfg_on = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pend_full", 32'(cfg_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready), 32'd1);
        $display("async reset asserted mid-run");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse(1'b1, 1'b0);
        sb.push_back(mk(4'b0000));
        sb.push_back(mk(4'b0000));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
Sequences a bank of LED blink channels from one shared prescaler counter. Each channel gets a programmable period and on-time in prescaler ticks. A valid/ready config port loads channel settings, and a start/stop FSM controls the shared counter. Running channels are updated only at tick boundaries, so a change never produces a glitched LED pulse.

Parameters:
NCH, 4, number of LED channels (>=1)
CBITS, 20, prescaler width; one tick every 2^CBITS clocks
PBITS, 8, width of per-channel period and on-time fields

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle request: IDLE -> RUN
stop  input  1  one-cycle request: RUN -> STOPPING
cfg_valid  input  1  config word valid
cfg_ready  output  1  config word accepted when cfg_valid && cfg_ready
cfg_ch  input  max(1,$clog2(NCH))  target channel; values >= NCH are accepted and dropped
cfg_period  input  PBITS  blink period in ticks; 0 = channel off
cfg_on  input  PBITS  on-time in ticks
led  output  NCH  registered LED outputs
tick  output  1  registered one-cycle pulse on prescaler wrap
busy  output  1  high in RUN and STOPPING

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, prescaler cnt=0.
  - All channel period/on/phase registers are 0; pending slot is empty.
  - led=0, tick=0, busy=0, cfg_ready=1.
- FSM states:
  - IDLE:
    - start -> RUN; cnt cleared to 0; all phases cleared to 0.
    - stop is ignored.
    - start and stop asserted together: start wins.
  - RUN:
    - cnt increments each clock, wrapping modulo 2^CBITS.
    - tick=1 on the cycle after cnt==2^CBITS-1, i.e. one clock wide every 2^CBITS clocks. The first tick comes 2^CBITS clocks after start.
    - stop -> STOPPING. start is ignored.
  - STOPPING:
    - Counting continues.
    - At the next tick: state goes to IDLE, led forced to 0, all phases cleared. Configs are kept.
    - start is ignored.
- Channel phase (on each tick in RUN/STOPPING, for each channel i):
  - If period[i]==0: phase[i]=0.
  - Otherwise: phase[i] = (phase[i]==period[i]-1) ? 0 : phase[i]+1.
- LED output:
  - led[i] = busy_next && period[i]!=0 && phase[i] < on[i].
  - Evaluated from next-state values and registered, so led changes in the same cycle tick rises.
  - on[i] >= period[i] -> constantly on. on[i]==0 -> constantly off.
- Config port:
  - IDLE: an accepted word writes period/on for cfg_ch on the next clock. cfg_ready stays 1.
  - RUN/STOPPING: an accepted word goes into a single pending slot and cfg_ready drops to 0.
  - At the next tick the pending word is applied to its channel, that channel's phase is set to 0 (its LED is evaluated from phase 0), and the slot frees (cfg_ready=1 the following cycle).
  - A word accepted on the same cycle tick asserts waits for the following tick.
  - Pending-slot contents are dropped if the FSM returns to IDLE without applying them. They are always applied at the STOPPING->IDLE tick.
- Widths: phase registers are PBITS wide. All comparisons are unsigned. No arithmetic overflow is possible because phase < period <= 2^PBITS-1.
- Reset mid-operation: immediate return to reset values. No pending write survives.

Test Plan:
1. CBITS=3. Configure ch0 period=4, on=2 in IDLE, then pulse start -> tick every 8 clocks starting 8 clocks after start. led[0] pattern per tick interval: 1,1,0,0 repeating; busy=1.
2. Configure ch1 period=3, on=5 and ch2 period=0, on=3 -> led[1] constantly 1 while running; led[2] constantly 0.
3. In RUN, write ch0 period=2, on=1 mid-interval -> cfg_ready=0 until the next tick. New pattern 1,0 starts at that tick with phase 0. The old pattern holds until then.
4. Pulse stop 3 clocks after a tick -> busy stays 1 and LEDs keep blinking for 5 more clocks. At the tick, led=0, busy=0, state IDLE. A later start resumes from phase 0 with the same configs.
5. Assert start and stop together in IDLE -> enters RUN. Pulse start during RUN -> no effect, tick cadence unchanged.
6. Drive rst=0 asynchronously mid-RUN with a pending config -> led, tick, busy immediately 0, cfg_ready=1. After release and start with no reconfiguration, all LEDs stay 0 (periods cleared).
